clint_timer: RTL

Machine-level core-local interruptor that generates the `MSIP` and `MTIP` inputs consumed by the CSR register file. It holds the 64-bit `mtime` counter, the 64-bit `mtimecomp` compare register and the `msip` software-interrupt bit, all memory-mapped on a simple single-word request/acknowledge bus from the load/store path. `MEIP` is outside this block's scope.

---
 rtl/clint_timer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/clint_timer.sv
// clint_timer: machine-level core-local interruptor.
// Holds the 64-bit mtime counter, the 64-bit mtimecmp compare register and
// the msip bit behind a single-word request/acknowledge bus, and drives the
// MSIP / MTIP interrupt lines.
// Optional feature macro: CLINT_PRESCALER_EN. When defined, mtime advances
// once every PRESCALE clk cycles; when undefined it advances every cycle and
// PRESCALE is ignored.
module clint_timer #(
   parameter int unsigned PRESCALE  = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
   input  logic        clk,
   input  logic        RSTN,
   input  logic        bus_req,
   input  logic        bus_we,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   output logic        bus_ready,
   output logic        bus_ack,
   output logic [31:0] bus_rdata,
   output logic        bus_err,
   output logic        MSIP,
   output logic        MTIP
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   // Word offsets (byte offset >> 2) of the mapped registers.
   localparam logic [29:0] W_MSIP    = 30'h0000;
   localparam logic [29:0] W_CMP_LO  = 30'h1000;
   localparam logic [29:0] W_CMP_HI  = 30'h1001;
   localparam logic [29:0] W_TIME_LO = 30'h2FFE;
   localparam logic [29:0] W_TIME_HI = 30'h2FFF;

   logic [0:0]  state_q, state_d;
   logic        msip_q, msip_d;
   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        mtip_q, mtip_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic        accept;
   logic        wr;
   logic        tick;
   logic [31:0] offset;
   logic        sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
   logic        hit;
   logic [31:0] rd_val;
   logic        unused_bits;

   assign accept = (state_q == ST_IDLE) && bus_req;
   assign wr     = accept && bus_we;

   assign offset      = bus_addr - BASE_ADDR;
   assign sel_msip    = (offset[31:2] == W_MSIP);
   assign sel_cmp_lo  = (offset[31:2] == W_CMP_LO);
   assign sel_cmp_hi  = (offset[31:2] == W_CMP_HI);
   assign sel_time_lo = (offset[31:2] == W_TIME_LO);
   assign sel_time_hi = (offset[31:2] == W_TIME_HI);
   assign hit = sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi;

`ifdef CLINT_PRESCALER_EN
   localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 1);

   logic [15:0] psc_q, psc_d;

   assign tick  = (psc_q == PSC_LAST);
   assign psc_d = tick ? 16'd0 : psc_q + 16'd1;

   // Prescaler: free-running 0..PRESCALE-1, never disturbed by bus writes.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) psc_q <= 16'd0;
      else       psc_q <= psc_d;
   end

   assign unused_bits = ^offset[1:0];
`else
   localparam logic [15:0] PSC_UNUSED = 16'(PRESCALE);

   assign tick        = 1'b1;
   assign unused_bits = ^{offset[1:0], PSC_UNUSED};
`endif

   // Read mux: value of the addressed register before the accepting edge.
   always_comb begin
      rd_val = 32'd0;
      if (sel_msip)    rd_val = {31'd0, msip_q};
      if (sel_cmp_lo)  rd_val = mtimecmp_q[31:0];
      if (sel_cmp_hi)  rd_val = mtimecmp_q[63:32];
      if (sel_time_lo) rd_val = mtime_q[31:0];
      if (sel_time_hi) rd_val = mtime_q[63:32];
   end

   // Next-state for the bus FSM, registers and response capture.
   // A write to either mtime half replaces the tick increment for that cycle;
   // the other half keeps its value with no carry applied.
   always_comb begin
      state_d    = (state_q == ST_IDLE) ? (accept ? ST_RESP : ST_IDLE) : ST_IDLE;

      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      if (wr && sel_time_lo) mtime_d = {mtime_q[63:32], bus_wdata};
      if (wr && sel_time_hi) mtime_d = {bus_wdata, mtime_q[31:0]};

      mtimecmp_d = mtimecmp_q;
      if (wr && sel_cmp_lo) mtimecmp_d = {mtimecmp_q[63:32], bus_wdata};
      if (wr && sel_cmp_hi) mtimecmp_d = {bus_wdata, mtimecmp_q[31:0]};

      msip_d     = (wr && sel_msip) ? bus_wdata[0] : msip_q;

      mtip_d     = (mtime_q >= mtimecmp_q);

      rdata_d    = rdata_q;
      err_d      = err_q;
      if (accept) begin
         rdata_d = bus_we ? 32'd0 : rd_val;
         err_d   = !hit;
      end
   end

   // State registers; reset aborts any response in flight.
   always_ff @(posedge clk or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= ST_IDLE;
         msip_q     <= 1'b0;
         mtime_q    <= 64'd0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         mtip_q     <= 1'b0;
         rdata_q    <= 32'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         msip_q     <= msip_d;
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         mtip_q     <= mtip_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

   assign bus_ready = (state_q == ST_IDLE);
   assign bus_ack   = (state_q == ST_RESP);
   assign bus_rdata = bus_ack ? rdata_q : 32'd0;
   assign bus_err   = bus_ack & err_q;
   assign MSIP      = msip_q;
   assign MTIP      = mtip_q;

endmodule
